snn_bram_sched: RTL and testbench

//  Owns the PS->PL handoff of the shared 4KB TDP BRAM and time-shares its PL Port A between NREQ
//  SNN engine requesters (weight fetch, membrane update, spike write-back, ...).
//  - Drives the BRAM ps_done select.
//  - Round-robin arbitrates word read/write beats, with optional burst lock.
//  - Returns read data one cycle after issue.
//  - Drains the in-flight read before handing the BRAM back to the PS.

---
 rtl/snn_bram_sched_pkg.sv | 11 +
 rtl/snn_bram_sched_arb.sv | 24 ++
 rtl/snn_bram_sched.sv | 98 +++++++++
 tb/tb_snn_bram_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_bram_sched_pkg.sv
// snn_bram_sched_pkg: ownership states, BRAM geometry and round-robin pointer update.
package snn_bram_sched_pkg;
  typedef enum logic [1:0] {PS_OWN, PL_OWN, DRAIN} state_e;
  localparam int BRAM_DW = 32;
  localparam int BRAM_BE = 4;
  localparam int PTR_W = 3;
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr, input logic [PTR_W-1:0] winner,
                                               input logic lock, input logic issue, input int nreq);
    return !issue ? ptr : lock ? winner : (int'(winner) == nreq - 1) ? '0 : winner + 1'b1;
  endfunction
endpackage

// File: rtl/snn_bram_sched_arb.sv
// snn_rr_arbiter: rotating-priority pick of the first valid requester at or after ptr.
module snn_rr_arbiter
  import snn_bram_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] winner,
  output logic             any
);
  int j;
  always_comb begin
    j = 0;
    winner = ptr;
    any = |valid;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (valid[j]) winner = PTR_W'(j);
    end
    grant = any ? (NREQ'(1) << winner) : '0;
  end
endmodule

// File: rtl/snn_bram_sched.sv
// snn_bram_sched: PS/PL BRAM ownership FSM and round-robin Port A scheduler.
// Optional per-requester beat/stall counters under SNN_BRAM_SCHED_PERF_EN.
module snn_bram_sched
  import snn_bram_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         s00_axi_aclk,
  input  logic                         s00_axi_aresetn,
  input  logic                         ps_release,
  input  logic                         pl_release,
  output logic                         ps_done,
  output logic                         run_done,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_lock,
  input  logic [NREQ*BRAM_BE-1:0]      req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NREQ*BRAM_DW-1:0]      req_wdata,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [BRAM_DW-1:0]           rsp_rdata,
  output logic                         ena_pl,
  output logic [BRAM_BE-1:0]           wea_pl,
  output logic [ADDR_WIDTH-1:0]        addra_pl,
  output logic [BRAM_DW-1:0]           dia_pl,
  input  logic [BRAM_DW-1:0]           doa_pl
`ifdef SNN_BRAM_SCHED_PERF_EN
  ,
  output logic [NREQ*32-1:0]           perf_beats,
  output logic [NREQ*32-1:0]           perf_stall
`endif
);
  state_e state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, winner;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d, grant;
  logic run_done_q, run_done_d, any, pl_own, issue;

  snn_rr_arbiter #(.NREQ(NREQ)) u_arb (.valid(req_valid), .ptr(ptr_q), .grant(grant), .winner(winner), .any(any));

  always_comb begin
    pl_own = state_q == PL_OWN;
    issue = pl_own && any;
    req_ready = pl_own ? grant : '0;
    ena_pl = issue;
    wea_pl = issue ? req_we[int'(winner)*BRAM_BE +: BRAM_BE] : '0;
    addra_pl = issue ? req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    dia_pl = issue ? req_wdata[int'(winner)*BRAM_DW +: BRAM_DW] : '0;
    state_d = state_q == PS_OWN ? (ps_release ? PL_OWN : PS_OWN) :
              state_q == PL_OWN ? (pl_release ? DRAIN : PL_OWN) : PS_OWN;
    ptr_d = rr_next(ptr_q, winner, req_lock[winner], issue, NREQ);
    rsp_valid_d = (issue && wea_pl == '0) ? grant : '0;
    run_done_d = state_q == DRAIN;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      state_q <= PS_OWN;
      ptr_q <= '0;
      rsp_valid_q <= '0;
      run_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      run_done_q <= run_done_d;
    end

  // BRAM output register already holds the word in the cycle after issue
  assign ps_done = state_q != PS_OWN;
  assign run_done = run_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = |rsp_valid_q ? doa_pl : '0;

`ifdef SNN_BRAM_SCHED_PERF_EN
  logic [NREQ-1:0][31:0] beats_q, beats_d, stall_q, stall_d;
  logic clr;
  always_comb begin
    clr = ps_release && state_q == PS_OWN;
    beats_d = beats_q;
    stall_d = stall_q;
    for (int i = 0; i < NREQ; i++) begin
      beats_d[i] = clr ? '0 : beats_q[i] + 32'(issue && winner == PTR_W'(i) && beats_q[i] != '1);
      stall_d[i] = clr ? '0 : stall_q[i] + 32'(pl_own && req_valid[i] && !req_ready[i] && stall_q[i] != '1);
    end
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  assign perf_beats = beats_q;
  assign perf_stall = stall_q;
`endif
endmodule

// File: tb/tb_snn_bram_sched.sv
// tb_snn_bram_sched: directed checks of ownership handoff, arbitration, lock, responses and writes.
module tb_snn_bram_sched;
  logic clk = 1'b0, rst_n = 1'b0, ps_release = 1'b0, pl_release = 1'b0;
  logic ps_done, run_done, ena_pl;
  logic [3:0] req_valid = '0, req_lock = '0, req_ready, rsp_valid, wea_pl;
  logic [15:0] req_we = '0;
  logic [39:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [31:0] rsp_rdata, dia_pl, doa_pl;
  logic [9:0] addra_pl;
  logic [31:0] mem [1024];
  int n_tests = 0, n_fail = 0;
`ifdef SNN_BRAM_SCHED_PERF_EN
  logic [127:0] perf_beats, perf_stall;
`endif

  snn_bram_sched #(.NREQ(4), .ADDR_WIDTH(10)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .ps_release(ps_release), .pl_release(pl_release),
    .ps_done(ps_done), .run_done(run_done), .req_valid(req_valid), .req_ready(req_ready),
    .req_lock(req_lock), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ena_pl(ena_pl), .wea_pl(wea_pl),
    .addra_pl(addra_pl), .dia_pl(dia_pl), .doa_pl(doa_pl)
`ifdef SNN_BRAM_SCHED_PERF_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Registered-output BRAM model, read-first
  always @(posedge clk)
    if (ena_pl) begin
      doa_pl <= mem[addra_pl];
      for (int b = 0; b < 4; b++) if (wea_pl[b]) mem[addra_pl][b*8 +: 8] <= dia_pl[b*8 +: 8];
    end

  function automatic logic [31:0] pre(input int a);
    return 32'hC0DE0000 ^ 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_ena"}, 32'(ena_pl), 32'h0);
    chk({tag, "_wea"}, 32'(wea_pl), 32'h0);
    chk({tag, "_addra"}, 32'(addra_pl), 32'h0);
    chk({tag, "_dia"}, dia_pl, 32'h0);
  endtask

  initial begin
    doa_pl = '0;
    for (int i = 0; i < 1024; i++) mem[i] = pre(i);
    mem[10'h3FF] = 32'hAABBCCDD;
    // 1: reset and handoff to PL
    #12;
    chk("rst_ps_done", 32'(ps_done), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk_idle("rst");
    rst_n = 1'b1;
    tick;
    chk("post_rst_ps_done", 32'(ps_done), 32'h0);
    chk("post_rst_run_done", 32'(run_done), 32'h0);
    chk("post_rst_rdata", rsp_rdata, 32'h0);
    ps_release = 1'b1;
    settle;
    chk("pre_own_ps_done", 32'(ps_done), 32'h0);
    tick;
    ps_release = 1'b0;
    chk("own_ps_done", 32'(ps_done), 32'h1);
    // 2: alternating reads by req0 and req2
    req_addr[0 +: 10] = 10'h010;
    req_addr[20 +: 10] = 10'h020;
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      settle;
      chk("rr_ready", 32'(req_ready), (k % 2) ? 32'h4 : 32'h1);
      chk("rr_addra", 32'(addra_pl), (k % 2) ? 32'h020 : 32'h010);
      if (k > 0) begin
        chk("rr_rsp_valid", 32'(rsp_valid), (k % 2) ? 32'h1 : 32'h4);
        chk("rr_rdata", rsp_rdata, (k % 2) ? pre(16) : pre(32));
      end
      tick;
    end
    req_valid = 4'b0000;
    settle;
    chk("rr_last_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("rr_last_rdata", rsp_rdata, pre(32));
    chk("rr_idle_ready", 32'(req_ready), 32'h0);
    chk("rr_idle_ena", 32'(ena_pl), 32'h0);
    tick;
    chk("rr_no_rsp", 32'(rsp_valid), 32'h0);
    // 3: lock, ptr is now 3
    req_addr[10 +: 10] = 10'h030;
    req_addr[30 +: 10] = 10'h040;
    req_valid = 4'b0010;
    req_lock = 4'b0010;
    settle;
    chk("lock_g1", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b1010;
    settle;
    chk("lock_g2", 32'(req_ready), 32'h2);
    chk("lock_rsp1", 32'(rsp_valid), 32'h2);
    chk("lock_rdata1", rsp_rdata, pre(48));
    tick;
    settle;
    chk("lock_g3", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b1000;
    req_lock = 4'b0000;
    settle;
    chk("lock_then_req3", 32'(req_ready), 32'h8);
    chk("lock_addra3", 32'(addra_pl), 32'h040);
    tick;
    req_valid = 4'b0000;
    settle;
    chk("lock_rsp3", 32'(rsp_valid), 32'h8);
    chk("lock_rdata3", rsp_rdata, pre(64));
    tick;
    // 4: pl_release together with a read issue by req2, ptr is 0
    req_addr[20 +: 10] = 10'h050;
    req_valid = 4'b0100;
    pl_release = 1'b1;
    settle;
    chk("ho_ready", 32'(req_ready), 32'h4);
    chk("ho_ena", 32'(ena_pl), 32'h1);
    tick;
    pl_release = 1'b0;
    settle;
    chk("drain_ps_done", 32'(ps_done), 32'h1);
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("drain_rdata", rsp_rdata, pre(80));
    chk("drain_run_done", 32'(run_done), 32'h0);
    chk_idle("drain");
    tick;
    chk("back_ps_done", 32'(ps_done), 32'h0);
    chk("back_run_done", 32'(run_done), 32'h1);
    chk("back_rsp_valid", 32'(rsp_valid), 32'h0);
    // 5: requests and pl_release are ignored in PS_OWN
    chk_idle("psown");
    tick;
    chk("run_done_pulse", 32'(run_done), 32'h0);
    req_valid = 4'b0000;
    pl_release = 1'b1;
    tick;
    pl_release = 1'b0;
    chk("psown_pl_release", 32'(ps_done), 32'h0);
    ps_release = 1'b1;
    tick;
    chk("reown_ps_done", 32'(ps_done), 32'h1);
    tick;
    ps_release = 1'b0;
    chk("ps_release_in_pl", 32'(ps_done), 32'h1);
    tick;
    chk("still_pl", 32'(ps_done), 32'h1);
    // 6: byte-masked write by req3 then readback, ptr is 3
    req_valid = 4'b1000;
    req_addr[30 +: 10] = 10'h3FF;
    req_we[12 +: 4] = 4'b0101;
    req_wdata[96 +: 32] = 32'h11223344;
    settle;
    chk("wr_ready", 32'(req_ready), 32'h8);
    chk("wr_wea", 32'(wea_pl), 32'h5);
    chk("wr_addra", 32'(addra_pl), 32'h3FF);
    chk("wr_dia", dia_pl, 32'h11223344);
    tick;
    req_we[12 +: 4] = 4'b0000;
    settle;
    chk("wr_no_rsp", 32'(rsp_valid), 32'h0);
    chk("rd_ready", 32'(req_ready), 32'h8);
    chk("rd_wea", 32'(wea_pl), 32'h0);
    tick;
    req_valid = 4'b0000;
    settle;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("rd_rdata", rsp_rdata, 32'hAA22CC44);
`ifdef SNN_BRAM_SCHED_PERF_EN
    chk("perf_beats3", perf_beats[96 +: 32], 32'd2);
`endif
    tick;
    // 7: asynchronous reset with a read response pending
    req_addr[0 +: 10] = 10'h010;
    req_valid = 4'b0001;
    tick;
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("arst_ps_done", 32'(ps_done), 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_rdata", rsp_rdata, 32'h0);
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
